pc_fetch_unit: RTL and testbench

//  Parametrised successor to pcR32I: RV32I program counter with a valid/ready fetch port to instruction memory.

---
 rtl/pc_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   RV32I program counter with a valid/ready fetch port to instruction memory.
//   Resolves conditional branches and JAL/JALR jumps. A taken redirect that
//   arrives while a fetch request is stalled by memory is held until that
//   request is accepted. Misaligned taken targets are flagged and halt fetch.
//
// Ports
//   clock, reset            rising-edge clock, async active-low reset
//   Stall                   suppress new fetch requests (RUN only)
//   FetchReady              I-memory accepts FetchAddr this cycle
//   FetchValid, FetchAddr   fetch request and address (current PC)
//   BranchValid             branch/jump resolution presented this cycle
//   TestBranch, AlwaysBranch, AbsoluteBranch, PCBranchType
//                           branch kind, target mode and condition code
//   EQ, NE, LT, LTU, GE, GEU ALU compare flags
//   BranchPC, BranchAddr    resolving PC and offset/absolute target
//   Flush                   one-cycle pulse, discard younger instructions
//   MisalignErr, ErrAddr    sticky misaligned-target flag and captured target
//
// PCBranchType uses the RV32I funct3 encoding: BEQ=000 BNEQ=001 BLT=100
// BGE=101 BLTU=110 BGEU=111; 010 and 011 never take.

module pc_fetch_unit #(
   parameter int unsigned          DATA_W       = 32,
   parameter logic [DATA_W-1:0]    RESET_VECTOR = '0,
   parameter int unsigned          INSTR_BYTES  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              Stall,
   input  logic              FetchReady,
   output logic              FetchValid,
   output logic [DATA_W-1:0] FetchAddr,
   input  logic              BranchValid,
   input  logic              TestBranch,
   input  logic              AlwaysBranch,
   input  logic              AbsoluteBranch,
   input  logic [2:0]        PCBranchType,
   input  logic              EQ,
   input  logic              NE,
   input  logic              LT,
   input  logic              LTU,
   input  logic              GE,
   input  logic              GEU,
   input  logic [DATA_W-1:0] BranchPC,
   input  logic [DATA_W-1:0] BranchAddr,
   output logic              Flush,
   output logic              MisalignErr,
   output logic [DATA_W-1:0] ErrAddr
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_PEND = 2'd2;
   localparam logic [1:0] S_HALT = 2'd3;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNEQ = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] r_tgt;
   logic              r_err;
   logic [DATA_W-1:0] r_err_addr;

   logic [1:0]        w_state_nxt;
   logic [DATA_W-1:0] w_pc_nxt;
   logic [DATA_W-1:0] w_tgt_nxt;
   logic              w_err_nxt;
   logic [DATA_W-1:0] w_err_addr_nxt;

   logic              w_cond;
   logic              w_taken;
   logic [DATA_W-1:0] w_target;
   logic              w_misalign;
   logic              w_accept;
   logic [DATA_W-1:0] w_pc_inc;

   always_comb begin
      case (PCBranchType)
         BR_BEQ:  w_cond = EQ;
         BR_BNEQ: w_cond = NE;
         BR_BLT:  w_cond = LT;
         BR_BGE:  w_cond = GE;
         BR_BLTU: w_cond = LTU;
         BR_BGEU: w_cond = GEU;
         default: w_cond = 1'b0;
      endcase
   end

   assign w_taken    = BranchValid & (AlwaysBranch | (TestBranch & w_cond));
   assign w_target   = AbsoluteBranch ? {BranchAddr[DATA_W-1:1], 1'b0}
                                      : BranchPC + BranchAddr;
   assign w_misalign = |w_target[1:0];
   assign w_pc_inc   = r_pc + DATA_W'(INSTR_BYTES);

   // PEND keeps the already-issued request alive regardless of Stall.
   assign FetchValid  = ((r_state == S_RUN) & ~Stall) | (r_state == S_PEND);
   assign w_accept    = FetchValid & FetchReady;
   assign FetchAddr   = r_pc;
   assign Flush       = (r_state == S_RUN) & w_taken;
   assign MisalignErr = r_err;
   assign ErrAddr     = r_err_addr;

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_tgt_nxt      = r_tgt;
      w_err_nxt      = r_err;
      w_err_addr_nxt = r_err_addr;
      case (r_state)
         S_IDLE: w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_taken) begin
               if (w_misalign) begin
                  w_err_nxt      = 1'b1;
                  w_err_addr_nxt = w_target;
                  w_state_nxt    = S_HALT;
               end else if (FetchValid & ~FetchReady) begin
                  // Address must stay put until memory takes it.
                  w_tgt_nxt   = w_target;
                  w_state_nxt = S_PEND;
               end else begin
                  w_pc_nxt = w_target;
               end
            end else if (w_accept) begin
               w_pc_nxt = w_pc_inc;
            end
         end
         S_PEND: begin
            if (FetchReady) begin
               w_pc_nxt    = r_tgt;
               w_state_nxt = S_RUN;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_VECTOR;
         r_tgt      <= '0;
         r_err      <= 1'b0;
         r_err_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_tgt      <= w_tgt_nxt;
         r_err      <= w_err_nxt;
         r_err_addr <= w_err_addr_nxt;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        Stall = 1'b0, FetchReady = 1'b0;
   logic        FetchValid;
   logic [31:0] FetchAddr;
   logic        BranchValid = 1'b0, TestBranch = 1'b0, AlwaysBranch = 1'b0;
   logic        AbsoluteBranch = 1'b0;
   logic [2:0]  PCBranchType = 3'b000;
   logic        EQ = 0, NE = 0, LT = 0, LTU = 0, GE = 0, GEU = 0;
   logic [31:0] BranchPC = '0, BranchAddr = '0;
   logic        Flush, MisalignErr;
   logic [31:0] ErrAddr;

   int tests = 0;
   int fails = 0;

   // Reference model: mode 0 = waiting out the post-reset cycle, 1 = running,
   // 2 = redirect waiting on an outstanding request, 3 = halted.
   int          m_mode, n_mode;
   logic [31:0] m_pc, n_pc, m_tgt, n_tgt, m_eaddr, n_eaddr;
   bit          m_err, n_err;

   pc_fetch_unit dut (
      .clock(clock), .reset(reset), .Stall(Stall), .FetchReady(FetchReady),
      .FetchValid(FetchValid), .FetchAddr(FetchAddr), .BranchValid(BranchValid),
      .TestBranch(TestBranch), .AlwaysBranch(AlwaysBranch),
      .AbsoluteBranch(AbsoluteBranch), .PCBranchType(PCBranchType),
      .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
      .BranchPC(BranchPC), .BranchAddr(BranchAddr), .Flush(Flush),
      .MisalignErr(MisalignErr), .ErrAddr(ErrAddr)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit cond_met(input logic [2:0] t);
      case (t)
         3'b000:  return EQ;
         3'b001:  return NE;
         3'b100:  return LT;
         3'b101:  return GE;
         3'b110:  return LTU;
         3'b111:  return GEU;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_check();
      bit          taken, exp_valid;
      logic [31:0] target;
      taken  = BranchValid && (AlwaysBranch || (TestBranch && cond_met(PCBranchType)));
      target = AbsoluteBranch ? (BranchAddr & 32'hFFFF_FFFE) : (BranchPC + BranchAddr);
      exp_valid = (m_mode == 1) ? !Stall : (m_mode == 2);
      chk("model FetchValid", {31'b0, FetchValid}, {31'b0, exp_valid});
      chk("model FetchAddr", FetchAddr, m_pc);
      chk("model Flush", {31'b0, Flush}, {31'b0, (m_mode == 1) && taken});
      chk("model MisalignErr", {31'b0, MisalignErr}, {31'b0, m_err});
      chk("model ErrAddr", ErrAddr, m_eaddr);
      n_mode = m_mode; n_pc = m_pc; n_tgt = m_tgt; n_err = m_err; n_eaddr = m_eaddr;
      case (m_mode)
         0: n_mode = 1;
         1: begin
            if (taken) begin
               if (target % 4 != 0) begin
                  n_mode = 3; n_err = 1; n_eaddr = target;
               end else if (exp_valid && !FetchReady) begin
                  n_mode = 2; n_tgt = target;
               end else begin
                  n_pc = target;
               end
            end else if (exp_valid && FetchReady) begin
               n_pc = m_pc + 32'd4;
            end
         end
         2: if (FetchReady) begin
            n_pc = m_tgt; n_mode = 1;
         end
         default: ;
      endcase
   endtask

   // Inputs are changed only at posedge+1; outputs compared at negedge.
   task automatic tick();
      @(negedge clock);
      model_check();
      @(posedge clock);
      #1;
      m_mode = n_mode; m_pc = n_pc; m_tgt = n_tgt; m_err = n_err; m_eaddr = n_eaddr;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("reset FetchAddr", FetchAddr, 32'h0);
      chk("reset FetchValid", {31'b0, FetchValid}, 32'h0);
      chk("reset MisalignErr", {31'b0, MisalignErr}, 32'h0);
      chk("reset ErrAddr", ErrAddr, 32'h0);
      m_mode = 0; m_pc = '0; m_tgt = '0; m_err = 0; m_eaddr = '0;
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic clr_br();
      BranchValid = 0; TestBranch = 0; AlwaysBranch = 0; AbsoluteBranch = 0;
      EQ = 0; NE = 0; LT = 0; LTU = 0; GE = 0; GEU = 0;
   endtask

   task automatic jump_abs(input logic [31:0] a);
      clr_br();
      BranchValid = 1; AlwaysBranch = 1; AbsoluteBranch = 1; BranchAddr = a;
   endtask

   initial begin
      m_mode = 0; m_pc = '0; m_tgt = '0; m_err = 0; m_eaddr = '0;
      @(posedge clock);
      #1;
      FetchReady = 1;
      do_reset();

      // Sequential fetch after reset release.
      #1 chk("idle FetchValid", {31'b0, FetchValid}, 32'h0);
      tick();
      chk("seq addr0", FetchAddr, 32'd0);
      chk("seq valid", {31'b0, FetchValid}, 32'h1);
      tick(); chk("seq addr4", FetchAddr, 32'd4);
      tick(); chk("seq addr8", FetchAddr, 32'd8);
      tick(); chk("seq addr12", FetchAddr, 32'd12);

      // BEQ taken then not taken.
      TestBranch = 1; BranchValid = 1; PCBranchType = 3'b000;
      BranchPC = 32'd8; BranchAddr = 32'd40; EQ = 1;
      #1 chk("beq flush", {31'b0, Flush}, 32'h1);
      tick();
      clr_br();
      #1 chk("beq target", FetchAddr, 32'd48);
      chk("beq flush gone", {31'b0, Flush}, 32'h0);
      TestBranch = 1; BranchValid = 1; EQ = 0;
      #1 chk("beq nt flush", {31'b0, Flush}, 32'h0);
      tick();
      clr_br();
      chk("beq nt seq", FetchAddr, 32'd52);

      // BNEQ with memory not ready -> pending redirect.
      TestBranch = 1; BranchValid = 1; PCBranchType = 3'b001; NE = 1;
      BranchPC = 32'd16; BranchAddr = 32'hFFFF_FFF8; FetchReady = 0;
      #1 chk("bne flush", {31'b0, Flush}, 32'h1);
      tick();
      clr_br();
      jump_abs(32'h100); Stall = 1;
      #1 chk("pend addr held", FetchAddr, 32'd52);
      chk("pend valid", {31'b0, FetchValid}, 32'h1);
      chk("pend no flush", {31'b0, Flush}, 32'h0);
      tick();
      clr_br(); Stall = 0; FetchReady = 1;
      tick();
      chk("pend redirect", FetchAddr, 32'd8);

      // Absolute jumps: aligned then misaligned.
      jump_abs(32'h25);
      tick();
      clr_br();
      chk("jalr aligned", FetchAddr, 32'h24);
      jump_abs(32'h22);
      tick();
      clr_br();
      chk("misalign err", {31'b0, MisalignErr}, 32'h1);
      chk("misalign addr", ErrAddr, 32'h22);
      tick(); tick();
      chk("halt valid", {31'b0, FetchValid}, 32'h0);

      // PC wrap and stall.
      do_reset();
      tick(); tick();
      jump_abs(32'hFFFF_FFF8);
      tick();
      clr_br();
      chk("wrap fff8", FetchAddr, 32'hFFFF_FFF8);
      tick(); chk("wrap fffc", FetchAddr, 32'hFFFF_FFFC);
      tick(); chk("wrap 0", FetchAddr, 32'h0);
      Stall = 1;
      #1 chk("stall valid", {31'b0, FetchValid}, 32'h0);
      tick();
      chk("stall addr", FetchAddr, 32'h0);
      Stall = 0;

      // Reset while pending.
      FetchReady = 0;
      jump_abs(32'h200);
      tick();
      clr_br();
      do_reset();
      FetchReady = 1;
      tick(); tick();
      chk("reset drops pend", FetchAddr, 32'h4);

      // Randomized run against the model.
      for (int i = 0; i < 4000; i++) begin
         if (m_mode == 3 && $urandom_range(0, 5) == 0) do_reset();
         else if ($urandom_range(0, 499) == 0) do_reset();
         Stall          = ($urandom_range(0, 4) == 0);
         FetchReady     = ($urandom_range(0, 2) != 0);
         BranchValid    = ($urandom_range(0, 3) == 0);
         TestBranch     = $urandom_range(0, 1);
         AlwaysBranch   = ($urandom_range(0, 3) == 0);
         AbsoluteBranch = $urandom_range(0, 1);
         PCBranchType   = 3'($urandom_range(0, 7));
         {EQ, NE, LT, LTU, GE, GEU} = 6'($urandom);
         BranchPC       = $urandom & 32'hFFFF_FFFC;
         BranchAddr     = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) BranchAddr = BranchAddr | 32'($urandom_range(1, 3));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
